// File: rtl/hermes_inj_arbiter.sv
`default_nettype none
// ==========================================================================
// hermes_inj_arbiter: packet-level round-robin share of one Hermes port.
// Rev 1.0
// ==========================================================================
module hermes_inj_arbiter #(
  parameter int N_REQ     = 2,
  parameter int FLIT_SIZE = 32,
  parameter int SIZE_W    = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [N_REQ-1:0]                    req_tx_i,
  input  logic [N_REQ-1:0][FLIT_SIZE-1:0]     req_data_i,
  output logic [N_REQ-1:0]                    req_credit_o,
  output logic                                tx_o,
  output logic [FLIT_SIZE-1:0]                data_o,
  input  logic                                credit_i,
  output logic [N_REQ-1:0]                    grant_o,
  output logic                                busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_SIZE    = 2'd2,
    S_PAYLOAD = 2'd3
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   last_q;
  logic [N_REQ-1:0]   grant_q;
  logic [SIZE_W-1:0]  cnt_q;

  logic [IDX_W-1:0]   win_d;
  logic [IDX_W:0]     cand;
  logic               found;
  logic               xfer;

  // Scan from last_q+1 upward with wrap; the previous owner is checked last.
  always_comb begin
    win_d = last_q;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req_tx_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win_d = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    tx_o         = 1'b0;
    data_o       = '0;
    req_credit_o = '0;
    if (state_q != S_IDLE) begin
      tx_o                  = req_tx_i[owner_q];
      data_o                = req_data_i[owner_q];
      req_credit_o[owner_q] = credit_i;
    end
  end

  assign xfer    = tx_o & credit_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      last_q  <= IDX_W'(N_REQ-1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|req_tx_i) begin
            owner_q <= win_d;
            grant_q <= N_REQ'(1) << win_d;
            state_q <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            state_q <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (xfer) begin
            cnt_q <= data_o[SIZE_W-1:0];
            if (data_o[SIZE_W-1:0] == '0) begin
              state_q <= S_IDLE;
              last_q  <= owner_q;
              grant_q <= '0;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (xfer) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == SIZE_W'(1)) begin
              state_q <= S_IDLE;
              last_q  <= owner_q;
              grant_q <= '0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
